life_quad_engine: RTL and testbench

- Responder for the phase/position strobe sequence issued by the simulation controller (write_array, run, pos, write_mem).
- Holds a toroidal Life grid of 2*QW x 2*QH cells, split into four quadrants selected by pos.
- Loads quadrants from cell memory, evaluates the next generation one quadrant at a time over multiple cycles, and writes quadrants back to memory.
- Sits between the controller and the cell/frame memory.

---
 rtl/life_pkg.sv | 19 +
 rtl/life_cell_rule.sv | 28 ++
 rtl/life_quad_engine.sv | 174 +++++++++++++++++
 tb/tb_life_quad_engine.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared definitions for the quadrant Life engine: FSM encoding, quadrant bit
// indexing and the birth/survive masks (bit n set = rule fires with n neighbours).
package life_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EVAL   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam logic [8:0] BIRTH_B3    = 9'b0_0000_1000;
    localparam logic [8:0] BIRTH_B36   = 9'b0_0100_1000;
    localparam logic [8:0] SURVIVE_S23 = 9'b0_0000_1100;

    function automatic int qbit(input int r, input int c, input int qw);
        return r * qw + c;
    endfunction

endpackage

// File: rtl/life_cell_rule.sv
// Next-state rule for one Life cell from its centre and eight neighbours.
// HIGHLIFE_EN selects B36/S23; otherwise standard B3/S23.
module life_cell_rule
    import life_pkg::*;
(
    input  logic       centre_i,
    input  logic [7:0] nbr_i,
    output logic       next_o
);

`ifdef HIGHLIFE_EN
    localparam logic [8:0] BIRTH_MASK = BIRTH_B36;
`else
    localparam logic [8:0] BIRTH_MASK = BIRTH_B3;
`endif

    logic [3:0] count;

    always_comb begin
        count = '0;
        for (int k = 0; k < 8; k++) begin
            count = count + 4'(nbr_i[k]);
        end
    end

    assign next_o = centre_i ? SURVIVE_S23[count] : BIRTH_MASK[count];

endmodule

// File: rtl/life_quad_engine.sv
// Toroidal Life grid of 2*QW x 2*QH cells, loaded, evaluated and stored one
// quadrant at a time under controller strobes. HIGHLIFE_EN switches the cell rule.
module life_quad_engine
    import life_pkg::*;
#(
    parameter int QW = 4,
    parameter int QH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_array,
    input  logic             run,
    input  logic [1:0]       pos,
    input  logic             write_mem,
    output logic [1:0]       mem_rd_addr,
    input  logic [QW*QH-1:0] mem_rd_data,
    output logic             mem_wr_en,
    output logic [1:0]       mem_wr_addr,
    output logic [QW*QH-1:0] mem_wr_data,
    output logic             busy,
    output logic             overrun,
    output logic             protocol_err,
    output logic [15:0]      gen_count
);

    localparam int GW  = 2 * QW;
    localparam int GH  = 2 * QH;
    localparam int QN  = QW * QH;
    localparam int CW  = $clog2(GW);
    localparam int RW  = $clog2(GH);
    localparam int QNW = (QN > 1) ? $clog2(QN) : 1;

    typedef logic [GH-1:0][GW-1:0] grid_t;

    grid_t           grid_q, grid_d, next_q, next_d;
    state_e          state_q, state_d;
    logic [1:0]      eval_q, eval_d;
    logic [RW-1:0]   row_q, row_d;
    logic [15:0]     gen_q, gen_d;
    logic            wr_en_q, wr_en_d;
    logic [1:0]      wr_addr_q, wr_addr_d;
    logic [QN-1:0]   wr_data_q, wr_data_d;
    logic            overrun_q, overrun_d;
    logic            perr_q, perr_d;

    logic            any_strobe, multi_strobe;
    logic [RW-1:0]   gr, gr_up, gr_dn;
    logic [CW-1:0]   gc  [QW];
    logic [CW-1:0]   gcl [QW];
    logic [CW-1:0]   gcr [QW];
    logic [QW-1:0]   cell_nxt;

    assign any_strobe   = write_array | run | write_mem;
    assign multi_strobe = (write_array & run) | (write_array & write_mem) | (run & write_mem);

    // Global row under evaluation and its toroidal neighbours
    assign gr    = row_q + (eval_q[1] ? RW'(QH) : RW'(0));
    assign gr_up = (gr == '0) ? RW'(GH - 1) : gr - 1'b1;
    assign gr_dn = (gr == RW'(GH - 1)) ? '0 : gr + 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < QW; gi++) begin : g_col
            assign gc[gi]  = CW'(gi) + (eval_q[0] ? CW'(QW) : CW'(0));
            assign gcl[gi] = (gc[gi] == '0) ? CW'(GW - 1) : gc[gi] - 1'b1;
            assign gcr[gi] = (gc[gi] == CW'(GW - 1)) ? '0 : gc[gi] + 1'b1;

            life_cell_rule u_rule (
                .centre_i (grid_q[gr][gc[gi]]),
                .nbr_i    ({grid_q[gr_up][gcl[gi]], grid_q[gr_up][gc[gi]], grid_q[gr_up][gcr[gi]],
                            grid_q[gr][gcl[gi]],                           grid_q[gr][gcr[gi]],
                            grid_q[gr_dn][gcl[gi]], grid_q[gr_dn][gc[gi]], grid_q[gr_dn][gcr[gi]]}),
                .next_o   (cell_nxt[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        grid_d    = grid_q;
        next_d    = next_q;
        eval_d    = eval_q;
        row_d     = row_q;
        gen_d     = gen_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        overrun_d = overrun_q;
        perr_d    = perr_q | multi_strobe;

        case (state_q)
            ST_IDLE: begin
                if (write_array) begin
                    for (int r = 0; r < QH; r++) begin
                        for (int c = 0; c < QW; c++) begin
                            grid_d[RW'((pos[1] ? QH : 0) + r)][CW'((pos[0] ? QW : 0) + c)] =
                                mem_rd_data[QNW'(qbit(r, c, QW))];
                        end
                    end
                end else if (run) begin
                    eval_d  = pos;
                    row_d   = '0;
                    state_d = ST_EVAL;
                end else if (write_mem) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = pos;
                    for (int r = 0; r < QH; r++) begin
                        for (int c = 0; c < QW; c++) begin
                            wr_data_d[QNW'(qbit(r, c, QW))] =
                                grid_q[RW'((pos[1] ? QH : 0) + r)][CW'((pos[0] ? QW : 0) + c)];
                        end
                    end
                end
            end
            ST_EVAL: begin
                overrun_d = overrun_q | any_strobe;
                for (int c = 0; c < QW; c++) begin
                    next_d[gr][gc[c]] = cell_nxt[c];
                end
                if (row_q == RW'(QH - 1)) begin
                    row_d   = '0;
                    state_d = (eval_q == 2'd3) ? ST_COMMIT : ST_IDLE;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            ST_COMMIT: begin
                overrun_d = overrun_q | any_strobe;
                grid_d    = next_q;
                gen_d     = gen_q + 16'd1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            grid_q    <= '0;
            next_q    <= '0;
            eval_q    <= '0;
            row_q     <= '0;
            gen_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            overrun_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grid_q    <= grid_d;
            next_q    <= next_d;
            eval_q    <= eval_d;
            row_q     <= row_d;
            gen_q     <= gen_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            overrun_q <= overrun_d;
            perr_q    <= perr_d;
        end
    end

    assign mem_rd_addr  = pos;
    assign mem_wr_en    = wr_en_q;
    assign mem_wr_addr  = wr_addr_q;
    assign mem_wr_data  = wr_data_q;
    assign busy         = (state_q != ST_IDLE);
    assign overrun      = overrun_q;
    assign protocol_err = perr_q;
    assign gen_count    = gen_q;

endmodule

// File: tb/tb_life_quad_engine.sv
// Scoreboard bench for life_quad_engine on an 8x8 grid: expected memory writes
// are queued at issue time and checked by an independent write monitor.
module tb_life_quad_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        write_array = 1'b0;
    logic        run = 1'b0;
    logic        write_mem = 1'b0;
    logic [1:0]  pos = 2'd0;
    logic [1:0]  mem_rd_addr, mem_wr_addr;
    logic [15:0] mem_rd_data, mem_wr_data;
    logic        mem_wr_en, busy, overrun, protocol_err;
    logic [15:0] gen_count;

    logic [15:0] mem [4];
    logic [17:0] exp_q [$];
    logic [17:0] mon_e;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_rd_addr];

    life_quad_engine #(.QW(4), .QH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .write_array  (write_array),
        .run          (run),
        .pos          (pos),
        .write_mem    (write_mem),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .busy         (busy),
        .overrun      (overrun),
        .protocol_err (protocol_err),
        .gen_count    (gen_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Write monitor: every mem_wr_en pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (mem_wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_wr: got addr=%0d data=0x%h, expected no write", mem_wr_addr, mem_wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("wr_addr_q%0d", mon_e[17:16]), 32'(mem_wr_addr), 32'(mon_e[17:16]));
                check($sformatf("wr_data_q%0d", mon_e[17:16]), 32'(mem_wr_data), 32'(mon_e[15:0]));
            end
        end
    end

    task automatic strobe(input logic wa, input logic rn, input logic wm, input logic [1:0] p);
        @(negedge clk);
        write_array = wa;
        run         = rn;
        write_mem   = wm;
        pos         = p;
        @(negedge clk);
        write_array = 1'b0;
        run         = 1'b0;
        write_mem   = 1'b0;
    endtask

    task automatic do_run(input logic [1:0] p, input int exp_cyc);
        int cnt;
        strobe(1'b0, 1'b1, 1'b0, p);
        cnt = 0;
        while (busy && cnt < 32) begin
            cnt++;
            @(negedge clk);
        end
        check($sformatf("busy_cycles_q%0d", p), 32'(cnt), 32'(exp_cyc));
    endtask

    task automatic do_write_mem(input logic [1:0] p, input logic [15:0] exp);
        exp_q.push_back({p, exp});
        strobe(1'b0, 1'b0, 1'b1, p);
    endtask

    task automatic load_quad(input logic [1:0] p, input logic [15:0] data);
        mem[p] = data;
        strobe(1'b1, 1'b0, 1'b0, p);
    endtask

    task automatic run_generation();
        for (int q = 0; q < 4; q++) do_run(2'(q), (q == 3) ? 5 : 4);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Grid bit r*8+c -> quadrant word bit r*4+c
    function automatic logic [15:0] quad_of(input logic [63:0] g, input int q);
        logic [15:0] w;
        w = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                w[r*4+c] = g[((q/2)*4 + r)*8 + (q%2)*4 + c];
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] g0, g4;
        int          cnt;
        for (int i = 0; i < 4; i++) mem[i] = '0;

        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gen", 32'(gen_count), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_perr", 32'(protocol_err), 32'd0);
        check("rst_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_wr_data", 32'(mem_wr_data), 32'd0);

        // Blinker: horizontal row 1 cols 0..2 becomes vertical col 1 rows 0..2
        load_quad(2'd0, 16'h0070);
        run_generation();
        check("blinker_gen", 32'(gen_count), 32'd1);
        do_write_mem(2'd0, 16'h0222);
        do_write_mem(2'd1, 16'h0000);
        do_write_mem(2'd2, 16'h0000);
        do_write_mem(2'd3, 16'h0000);

        // Glider straddling the torus corner; 4 generations shift it by (+1,+1)
        apply_reset();
        g0 = '0;
        g0[6*8+7] = 1'b1; g0[7*8+0] = 1'b1; g0[0*8+6] = 1'b1; g0[0*8+7] = 1'b1; g0[0*8+0] = 1'b1;
        g4 = '0;
        g4[7*8+0] = 1'b1; g4[0*8+1] = 1'b1; g4[1*8+7] = 1'b1; g4[1*8+0] = 1'b1; g4[1*8+1] = 1'b1;
        for (int q = 0; q < 4; q++) load_quad(2'(q), quad_of(g0, q));
        for (int g = 0; g < 4; g++) run_generation();
        check("glider_gen", 32'(gen_count), 32'd4);
        for (int q = 0; q < 4; q++) do_write_mem(2'(q), quad_of(g4, q));

        // Overrun: write_array two cycles after run is dropped
        apply_reset();
        mem[0] = 16'hFFFF;
        strobe(1'b0, 1'b1, 1'b0, 2'd0);
        cnt = 0;
        while (busy && cnt < 32) begin
            write_array = (cnt == 1);
            cnt++;
            @(negedge clk);
        end
        write_array = 1'b0;
        check("ovr_busy_cycles", 32'(cnt), 32'd4);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_perr", 32'(protocol_err), 32'd0);
        do_write_mem(2'd0, 16'h0000);

        // Reset asserted during EVAL row 2 clears everything at once
        load_quad(2'd1, 16'h0070);
        run_generation();
        check("pre_rst_gen", 32'(gen_count), 32'd1);
        check("pre_rst_overrun", 32'(overrun), 32'd1);
        strobe(1'b0, 1'b1, 1'b0, 2'd3);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_gen", 32'(gen_count), 32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        check("midrst_perr", 32'(protocol_err), 32'd0);
        check("midrst_wr_en", 32'(mem_wr_en), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        do_write_mem(2'd1, 16'h0000);

        // write_array and run together: load wins, no evaluation, protocol_err
        mem[2] = 16'h1234;
        strobe(1'b1, 1'b1, 1'b0, 2'd2);
        check("both_no_eval", 32'(busy), 32'd0);
        check("both_perr", 32'(protocol_err), 32'd1);
        check("both_gen", 32'(gen_count), 32'd0);
        do_write_mem(2'd2, 16'h1234);

        // Dead cell (1,1) with 6 live neighbours
        load_quad(2'd0, 16'h0317);
        load_quad(2'd1, 16'h0000);
        load_quad(2'd2, 16'h0000);
        load_quad(2'd3, 16'h0000);
        run_generation();
        check("b6_gen", 32'(gen_count), 32'd1);
`ifdef HIGHLIFE_EN
        do_write_mem(2'd0, 16'h0363);
`else
        do_write_mem(2'd0, 16'h0343);
`endif
        do_write_mem(2'd1, 16'h0080);
        do_write_mem(2'd2, 16'h2000);
        do_write_mem(2'd3, 16'h0000);

        repeat (3) @(negedge clk);
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
